// File: rtl/nco_pkg.sv
// nco_pkg: shared constants and constant functions for the CORDIC NCO.
// Angle table, CORDIC gain and start-vector magnitude.
package nco_pkg;

   // CORDIC gain 0.6072529350 held as an integer scaled by 1e10
   localparam longint GAIN_E10 = 64'sd6072529350;
   localparam longint DEC_E10  = 64'sd10000000000;

   // atan(2^-i) / pi * 2^31, i = 0..31 (one half-turn = 2^31)
   localparam longint ATAN_T [32] = '{
      64'sd536870912, 64'sd316933406, 64'sd167458907, 64'sd85004756,
      64'sd42667331,  64'sd21354465,  64'sd10679838,  64'sd5340245,
      64'sd2670163,   64'sd1335087,   64'sd667544,    64'sd333772,
      64'sd166886,    64'sd83443,     64'sd41722,     64'sd20861,
      64'sd10430,     64'sd5215,      64'sd2608,      64'sd1304,
      64'sd652,       64'sd326,       64'sd163,       64'sd81,
      64'sd41,        64'sd20,        64'sd10,        64'sd5,
      64'sd3,         64'sd1,         64'sd1,         64'sd0
   };

   // atan_i = round(atan(2^-i) * 2^(w-1) / pi), w <= 32
   function automatic int atan_lut(input int i, input int w);
      longint t;
      t = ATAN_T[i];
      if (w < 32)
         t = (t + (longint'(1) << (31 - w))) >>> (32 - w);
      return int'(t);
   endfunction

   // Kc = round((2^(dw-1) - 2) * 0.6072529350)
   function automatic int kc_calc(input int dw);
      longint a;
      a = (longint'(1) << (dw - 1)) - 2;
      return int'((a * GAIN_E10 + DEC_E10 / 2) / DEC_E10);
   endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation.
// Direction follows the sign of the residual angle z.
module cordic_stage #(
   parameter int XW    = 18,
   parameter int ZW    = 16,
   parameter int SHIFT = 0,
   parameter int ATAN  = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [XW-1:0] x_i,
   input  logic [XW-1:0] y_i,
   input  logic [ZW-1:0] z_i,
   output logic [XW-1:0] x_o,
   output logic [XW-1:0] y_o,
   output logic [ZW-1:0] z_o
);

   localparam logic [ZW-1:0] ATAN_Z = ZW'(ATAN);

   logic [XW-1:0] xs, ys;
   logic [XW-1:0] x_d, x_q;
   logic [XW-1:0] y_d, y_q;
   logic [ZW-1:0] z_d, z_q;

   // shift-and-add rotation toward z = 0
   always_comb begin
      xs = XW'($signed(x_i) >>> SHIFT);
      ys = XW'($signed(y_i) >>> SHIFT);
      if (!z_i[ZW-1]) begin
         x_d = x_i - ys;
         y_d = y_i + xs;
         z_d = z_i - ATAN_Z;
      end else begin
         x_d = x_i + ys;
         y_d = y_i - xs;
         z_d = z_i + ATAN_Z;
      end
   end

   // stage register, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
         z_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         z_q <= z_d;
      end
   end

   assign x_o = x_q;
   assign y_o = y_q;
   assign z_o = z_q;

endmodule

// File: rtl/nco_cordic.sv
// nco_cordic: pipelined CORDIC phase-to-cos/sin converter.
// Pre-rotation register, then one register per micro-rotation.
module nco_cordic
   import nco_pkg::*;
#(
   parameter int width  = 16,
   parameter int dwidth = 16,
   parameter int stages = 16
) (
   input  logic              reset,
   input  logic              clk,
   input  logic [width-1:0]  phase,
   input  logic              in_valid,
   output logic [dwidth-1:0] cos_out,
   output logic [dwidth-1:0] sin_out,
   output logic              out_valid
);

   // two fractional guard bits below the output LSB
   localparam int XW = dwidth + 2;
   localparam int KC = kc_calc(dwidth);
   localparam logic [XW-1:0] KC4 = XW'(KC * 4);

   localparam logic signed [XW:0] RND  = (XW+1)'(2);
   localparam logic signed [XW:0] SMAX = (XW+1)'((1 << (dwidth-1)) - 1);
   localparam logic signed [XW:0] SMIN = -SMAX;

   logic             flip;
   logic [XW-1:0]    x0_d, x0_q;
   logic [XW-1:0]    y0_d, y0_q;
   logic [width-1:0] z0_d, z0_q;
   logic [stages:0]  vld_q;

   logic [XW-1:0]    xs [stages+1];
   logic [XW-1:0]    ys [stages+1];
   logic [width-1:0] zs [stages+1];
   logic [width-1:0] z_unused;

   // drop guard bits with round-half-up, clamp to +/-(2^(dw-1)-1)
   function automatic logic [dwidth-1:0] rnd_sat(input logic [XW-1:0] v);
      logic signed [XW:0] r;
      logic [dwidth-1:0]  o;
      r = ($signed({v[XW-1], v}) + RND) >>> 2;
      if (r > SMAX)
         o = dwidth'(SMAX);
      else if (r < SMIN)
         o = dwidth'(SMIN);
      else
         o = dwidth'(r);
      return o;
   endfunction

   // fold |angle| > pi/2 into the right half-plane by a pi rotation
   always_comb begin
      flip = phase[width-1] ^ phase[width-2];
      x0_d = flip ? -KC4 : KC4;
      y0_d = '0;
      z0_d = flip ? {~phase[width-1], phase[width-2:0]} : phase;
   end

   // pre-rotation register and valid shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0_q  <= '0;
         y0_q  <= '0;
         z0_q  <= '0;
         vld_q <= '0;
      end else begin
         x0_q  <= x0_d;
         y0_q  <= y0_d;
         z0_q  <= z0_d;
         vld_q <= {vld_q[stages-1:0], in_valid};
      end
   end

   assign xs[0] = x0_q;
   assign ys[0] = y0_q;
   assign zs[0] = z0_q;

   for (genvar g = 0; g < stages; g++) begin : g_stage
      cordic_stage #(
         .XW    (XW),
         .ZW    (width),
         .SHIFT (g),
         .ATAN  (atan_lut(g, width))
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .x_i   (xs[g]),
         .y_i   (ys[g]),
         .z_i   (zs[g]),
         .x_o   (xs[g+1]),
         .y_o   (ys[g+1]),
         .z_o   (zs[g+1])
      );
   end

   // final residual angle is not needed downstream
   assign z_unused = zs[stages];

   // output scaling from the last stage
   always_comb begin
      cos_out   = rnd_sat(xs[stages]);
      sin_out   = rnd_sat(ys[stages]);
      out_valid = vld_q[stages];
   end

endmodule

// File: doc/nco_cordic.md
NCO_CORDIC -- requirements
Module: nco_cordic

Interface
REQ-001 Parameter width, default 16: phase input width; phase is signed, full scale -2^(width-1)..2^(width-1)-1 maps to -π..π.
REQ-002 Parameter dwidth, default 16: output sample width, signed two's complement.
REQ-003 Parameter stages, default 16: number of CORDIC micro-rotation stages, 8 <= stages <= width.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 phase  input  width  signed phase sample from the upstream phase accumulator.
REQ-007 in_valid  input  1  phase is valid this cycle.
REQ-008 cos_out  output  dwidth  signed cosine of phase, amplitude A = 2^(dwidth-1)-2.
REQ-009 sin_out  output  dwidth  signed sine of phase, amplitude A.
REQ-010 out_valid  output  1  cos_out/sin_out are valid this cycle.

Function
REQ-011 Pipeline: 1 pre-rotation register stage followed by stages micro-rotation register stages; latency = stages+1 clocks from in_valid sample to out_valid; throughput 1 sample/clock.
REQ-012 Pre-rotation: if phase[width-1:width-2] is 01 or 10 (|angle| > π/2), x0 = -Kc, y0 = 0, z0 = phase + 2^(width-1) (modulo 2^width); else x0 = +Kc, y0 = 0, z0 = phase.
REQ-013 Kc = round(A × 0.6072529350) in internal scale; internal x/y datapath width = dwidth+2 guard bits; z width = width.
REQ-014 Stage i (0..stages-1): d = +1 if z >= 0 else -1; x' = x - d·(y >>> i); y' = y + d·(x >>> i); z' = z - d·atan_i, with atan_i = round(atan(2^-i) × 2^(width-1)/π); shifts arithmetic.
REQ-015 Output: final x -> cos_out, y -> sin_out, rounded (round-half-up) from internal width to dwidth and saturated to ±(2^(dwidth-1)-1).
REQ-016 Accuracy: |error| <= 4 LSB versus A·cos/A·sin of the input angle for every phase value with default parameters.
REQ-017 Valid: a stages+1 deep shift register carries in_valid; out_valid is its last bit; data registers advance every clock regardless of valid; outputs are don't-care when out_valid = 0.
REQ-018 Bubbles: in_valid gaps of any pattern propagate unchanged; no sample is lost, duplicated or reordered.
REQ-019 Wrap-around: phase = -2^(width-1) (−π) and phase = 2^(width-1)-1 both produce cos ≈ -A, sin ≈ 0 within REQ-016 tolerance; no overflow in z pre-rotation.
REQ-020 No back-pressure: block has no stall input; downstream always accepts.

Reset
REQ-021 On reset all valid bits, x, y, z registers, cos_out, sin_out SHALL be 0 and out_valid 0, asynchronously.
REQ-022 Reset asserted mid-stream discards all in-flight samples; after deassertion out_valid stays 0 for at least stages+1 clocks after the first new in_valid.

Structure
REQ-023 Package nco_pkg SHALL hold the atan table generation function, the CORDIC gain constant 0.6072529350, and the Kc computation function of dwidth.
REQ-024 One sub-module cordic_stage (parameters: shift index i, atan_i, widths) SHALL implement one registered micro-rotation; nco_cordic instantiates it stages times with a generate loop.

Verification
REQ-025 phase = 0, in_valid = 1 -> after 17 clocks out_valid = 1, cos_out = 32766 ±4, sin_out = 0 ±4.
REQ-026 phase = 16384 (π/2) -> cos_out = 0 ±4, sin_out = 32766 ±4; phase = 8192 (π/4) -> both 23169 ±4.
REQ-027 phase = -32768 and 32767 -> cos_out = -32766 ±4, sin_out = 0 ±4; phase = -16384 -> sin_out = -32766 ±4.
REQ-028 Upstream phase accumulator with K = 1 sweeps all 65536 phases continuously -> every output within ±4 LSB of model, out_valid high continuously after 17 clocks, no saturation beyond ±32767.
REQ-029 in_valid pattern 1,0,0,1,1,0,1 with distinct phases -> out_valid shows identical pattern delayed 17 clocks, results in order.
REQ-030 Reset asserted for 1 clock while 10 samples in flight -> out_valid 0 immediately and until 17 clocks after next in_valid; cos_out/sin_out read 0 during reset.
